// File: rtl/centroid_update_unit.sv
// -----------------------------------------------------------------------------
// centroid_update_unit
//
// Centroid update stage of a K-means processor with K = 3 clusters. During a
// clustering pass it accumulates, per cluster, the sum of x, the sum of y and
// the number of points routed to it by the least-distance stage. After the
// point flagged as last, each centroid (sum / count, floor) is computed with a
// bit-serial restoring divider and streamed out over a valid/ready interface,
// cluster 0 first.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   pt_valid/pt_ready   : point handshake (ready only while accumulating)
//   pt_x, pt_y          : unsigned point coordinates
//   cluster_addr        : winning cluster 0..2 (3 is illegal, point dropped)
//   pt_last             : marks the final point of the pass
//   cent_valid/ready    : centroid handshake
//   cent_idx            : cluster index of the presented centroid
//   cent_x, cent_y      : centroid coordinates
//   cent_empty          : cluster got no points (coordinates are 0)
//   err_addr            : sticky, an illegal address was seen this pass
//   err_ovf             : sticky, a point was dropped on a saturated counter
// -----------------------------------------------------------------------------
module centroid_update_unit #(
    parameter int COORD_W = 16,
    parameter int CNT_W   = 16,
    parameter int SUM_W   = COORD_W + CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pt_valid,
    output logic               pt_ready,
    input  logic [COORD_W-1:0] pt_x,
    input  logic [COORD_W-1:0] pt_y,
    input  logic [1:0]         cluster_addr,
    input  logic               pt_last,
    output logic               cent_valid,
    input  logic               cent_ready,
    output logic [1:0]         cent_idx,
    output logic [COORD_W-1:0] cent_x,
    output logic [COORD_W-1:0] cent_y,
    output logic               cent_empty,
    output logic               err_addr,
    output logic               err_ovf
);

    localparam int BIT_W = $clog2(SUM_W);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DIV_X = 2'd1,
        DIV_Y = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SUM_W-1:0]   r_sum_x [3];
    logic [SUM_W-1:0]   r_sum_y [3];
    logic [CNT_W-1:0]   r_count [3];

    logic [1:0]         r_k;
    logic [BIT_W-1:0]   r_bit;
    logic [CNT_W-1:0]   r_rem;
    logic [COORD_W-2:0] r_quo;

    logic               r_pt_ready;
    logic               r_cent_valid;
    logic [COORD_W-1:0] r_cent_x;
    logic [COORD_W-1:0] r_cent_y;
    logic               r_cent_empty;
    logic               r_err_addr;
    logic               r_err_ovf;

    // ---------------------------------------------------------------- input side
    logic               w_accept;
    logic               w_addr_legal;
    logic [CNT_W-1:0]   w_addr_cnt;
    logic               w_cnt_sat;
    logic               w_acc_en;

    assign w_accept     = pt_valid & r_pt_ready;
    assign w_addr_legal = (cluster_addr != 2'b11);

    // NOTE: every signal written in always_comb gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        w_addr_cnt = '0;
        case (cluster_addr)
            2'd0:    w_addr_cnt = r_count[0];
            2'd1:    w_addr_cnt = r_count[1];
            2'd2:    w_addr_cnt = r_count[2];
            default: w_addr_cnt = '0;
        endcase
    end

    assign w_cnt_sat = &w_addr_cnt;
    assign w_acc_en  = w_accept & w_addr_legal & ~w_cnt_sat;

    // ---------------------------------------------------------- divider datapath
    logic [SUM_W-1:0]   w_cur_sum_x;
    logic [SUM_W-1:0]   w_cur_sum_y;
    logic [CNT_W-1:0]   w_cur_cnt;
    logic [SUM_W-1:0]   w_dividend;
    logic               w_div_bit;
    logic [CNT_W-1:0]   w_rem_base;
    logic [CNT_W:0]     w_trial;
    logic [CNT_W:0]     w_diff;
    logic               w_fits;
    logic [CNT_W-1:0]   w_rem_next;
    logic [COORD_W-1:0] w_quo_next;
    logic               w_last_bit;
    logic               w_cnt_zero;
    logic               w_handshake;
    logic               w_final_hs;

    always_comb begin
        w_cur_sum_x = '0;
        w_cur_sum_y = '0;
        w_cur_cnt   = '0;
        case (r_k)
            2'd0: begin
                w_cur_sum_x = r_sum_x[0];
                w_cur_sum_y = r_sum_y[0];
                w_cur_cnt   = r_count[0];
            end
            2'd1: begin
                w_cur_sum_x = r_sum_x[1];
                w_cur_sum_y = r_sum_y[1];
                w_cur_cnt   = r_count[1];
            end
            2'd2: begin
                w_cur_sum_x = r_sum_x[2];
                w_cur_sum_y = r_sum_y[2];
                w_cur_cnt   = r_count[2];
            end
            default: ;
        endcase
    end

    // The dividend is read straight out of the accumulator, MSB first, so no
    // load cycle is needed. The partial remainder is always below the divisor
    // and therefore fits in CNT_W bits; the borrow of the trial subtraction
    // decides the quotient bit.
    assign w_dividend = (r_state == DIV_Y) ? w_cur_sum_y : w_cur_sum_x;
    assign w_div_bit  = w_dividend[BIT_W'(SUM_W - 1) - r_bit];
    assign w_rem_base = (r_bit == '0) ? '0 : r_rem;
    assign w_trial    = {w_rem_base, w_div_bit};
    assign w_diff     = w_trial - {1'b0, w_cur_cnt};
    assign w_fits     = ~w_diff[CNT_W];
    assign w_rem_next = w_fits ? w_diff[CNT_W-1:0] : w_trial[CNT_W-1:0];
    // Only the low COORD_W quotient bits are kept; the upper ones are always 0
    // because a mean never exceeds the largest coordinate.
    assign w_quo_next = {r_quo, w_fits};
    assign w_last_bit = (r_bit == BIT_W'(SUM_W - 1));
    assign w_cnt_zero = (w_cur_cnt == '0);

    assign w_handshake = r_cent_valid & cent_ready;
    assign w_final_hs  = w_handshake & (r_k == 2'd2);

    // --------------------------------------------------------------------- FSM
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACCUM: if (w_accept && pt_last) w_state_next = DIV_X;
            DIV_X: begin
                if (w_cnt_zero)      w_state_next = OUT;
                else if (w_last_bit) w_state_next = DIV_Y;
            end
            DIV_Y: if (w_last_bit) w_state_next = OUT;
            OUT:   if (w_handshake) w_state_next = (r_k == 2'd2) ? ACCUM : DIV_X;
            default: w_state_next = ACCUM;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // always_ff samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ACCUM;
        else        r_state <= w_state_next;
    end

    // -------------------------------------------------------------- accumulators
    // NOTE: these small register arrays are reset explicitly because a reset
    // mid-pass must discard all accumulated data; they are flops, not RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                r_sum_x[i] <= '0;
                r_sum_y[i] <= '0;
                r_count[i] <= '0;
            end
        end else if (w_final_hs) begin
            for (int i = 0; i < 3; i++) begin
                r_sum_x[i] <= '0;
                r_sum_y[i] <= '0;
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_acc_en && cluster_addr == 2'(i)) begin
                    r_sum_x[i] <= r_sum_x[i] + SUM_W'(pt_x);
                    r_sum_y[i] <= r_sum_y[i] + SUM_W'(pt_y);
                    r_count[i] <= r_count[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_addr <= 1'b0;
            r_err_ovf  <= 1'b0;
        end else if (w_final_hs) begin
            r_err_addr <= 1'b0;
            r_err_ovf  <= 1'b0;
        end else begin
            if (w_accept && !w_addr_legal)             r_err_addr <= 1'b1;
            if (w_accept && w_addr_legal && w_cnt_sat) r_err_ovf  <= 1'b1;
        end
    end

    // ------------------------------------------------------ cluster index, divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k <= 2'd0;
        end else if (r_state == ACCUM && w_accept && pt_last) begin
            r_k <= 2'd0;
        end else if (w_handshake) begin
            r_k <= (r_k == 2'd2) ? 2'd0 : r_k + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit <= '0;
            r_rem <= '0;
            r_quo <= '0;
        end else if ((r_state == DIV_X && !w_cnt_zero) || r_state == DIV_Y) begin
            r_bit <= w_last_bit ? '0 : r_bit + 1'b1;
            r_rem <= w_rem_next;
            r_quo <= w_quo_next[COORD_W-2:0];
        end else begin
            r_bit <= '0;
        end
    end

    // ------------------------------------------------------------------ outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cent_x     <= '0;
            r_cent_y     <= '0;
            r_cent_empty <= 1'b0;
        end else if (r_state == DIV_X) begin
            if (w_cnt_zero) begin
                r_cent_x     <= '0;
                r_cent_y     <= '0;
                r_cent_empty <= 1'b1;
            end else if (w_last_bit) begin
                r_cent_x     <= w_quo_next;
                r_cent_empty <= 1'b0;
            end
        end else if (r_state == DIV_Y && w_last_bit) begin
            r_cent_y <= w_quo_next;
        end
    end

    // cent_valid trails entry into OUT by one edge, giving the result registers
    // a full cycle before presentation; it drops on the edge of the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cent_valid <= 1'b0;
            r_pt_ready   <= 1'b0;
        end else begin
            r_cent_valid <= (r_state == OUT) && !w_handshake;
            r_pt_ready   <= (w_state_next == ACCUM);
        end
    end

    assign pt_ready   = r_pt_ready;
    assign cent_valid = r_cent_valid;
    assign cent_idx   = r_k;
    assign cent_x     = r_cent_x;
    assign cent_y     = r_cent_y;
    assign cent_empty = r_cent_empty;
    assign err_addr   = r_err_addr;
    assign err_ovf    = r_err_ovf;

endmodule

// File: tb/tb_centroid_update_unit.sv
// -----------------------------------------------------------------------------
// Directed testbench for centroid_update_unit. Expected centroids are
// hand-computed floor means of the points sent in each pass.
// -----------------------------------------------------------------------------
module tb_centroid_update_unit;

    localparam int COORD_W = 16;
    localparam int CNT_W   = 16;
    localparam int SUM_W   = COORD_W + CNT_W;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               pt_valid = 1'b0;
    logic               pt_ready;
    logic [COORD_W-1:0] pt_x = '0;
    logic [COORD_W-1:0] pt_y = '0;
    logic [1:0]         cluster_addr = '0;
    logic               pt_last = 1'b0;
    logic               cent_valid;
    logic               cent_ready = 1'b0;
    logic [1:0]         cent_idx;
    logic [COORD_W-1:0] cent_x;
    logic [COORD_W-1:0] cent_y;
    logic               cent_empty;
    logic               err_addr;
    logic               err_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    centroid_update_unit #(
        .COORD_W(COORD_W),
        .CNT_W  (CNT_W),
        .SUM_W  (SUM_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pt_valid    (pt_valid),
        .pt_ready    (pt_ready),
        .pt_x        (pt_x),
        .pt_y        (pt_y),
        .cluster_addr(cluster_addr),
        .pt_last     (pt_last),
        .cent_valid  (cent_valid),
        .cent_ready  (cent_ready),
        .cent_idx    (cent_idx),
        .cent_x      (cent_x),
        .cent_y      (cent_y),
        .cent_empty  (cent_empty),
        .err_addr    (err_addr),
        .err_ovf     (err_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y,
                        input logic [1:0] a, input logic last);
        int guard;
        guard        = 0;
        pt_valid     = 1'b1;
        pt_x         = x;
        pt_y         = y;
        cluster_addr = a;
        pt_last      = last;
        while (!pt_ready && guard < 200) begin
            tick();
            guard++;
        end
        if (!pt_ready) check("send_timeout", 64'd0, 64'd1);
        tick();
        pt_valid = 1'b0;
        pt_last  = 1'b0;
    endtask

    task automatic wait_cent(output int cycles);
        cycles = 0;
        while (!cent_valid && cycles < 500) begin
            tick();
            cycles++;
        end
        if (!cent_valid) check("cent_timeout", 64'd0, 64'd1);
    endtask

    task automatic expect_cent(input string tag, input logic [1:0] idx,
                               input logic [15:0] x, input logic [15:0] y,
                               input logic empty);
        int c;
        wait_cent(c);
        check({tag, "_idx"},   64'(cent_idx),   64'(idx));
        check({tag, "_x"},     64'(cent_x),     64'(x));
        check({tag, "_y"},     64'(cent_y),     64'(y));
        check({tag, "_empty"}, 64'(cent_empty), 64'(empty));
    endtask

    task automatic handshake();
        cent_ready = 1'b1;
        tick();
        cent_ready = 1'b0;
    endtask

    function automatic logic [38:0] all_outs();
        return {pt_ready, cent_valid, cent_idx, cent_x, cent_y, cent_empty, err_addr, err_ovf};
    endfunction

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c;
        bit  stable;

        // ---------------- reset
        tick();
        tick();
        check("reset_outs", 64'(all_outs()), 64'd0);
        rst_n = 1'b1;
        check("ready_before_edge", 64'(pt_ready), 64'd0);
        tick();
        check("ready_after_release", 64'(pt_ready), 64'd1);

        // ---------------- pass 1: basic means and latency
        send(16'd10, 16'd20, 2'd0, 1'b0);
        send(16'd12, 16'd22, 2'd0, 1'b0);
        send(16'd14, 16'd27, 2'd0, 1'b0);
        send(16'd100, 16'd5, 2'd1, 1'b1);
        check("p1_ready_fall", 64'(pt_ready), 64'd0);
        wait_cent(c);
        check("p1_latency", 64'(c), 64'd65);
        expect_cent("p1_c0", 2'd0, 16'd12, 16'd23, 1'b0);
        handshake();
        check("p1_valid_fall", 64'(cent_valid), 64'd0);
        expect_cent("p1_c1", 2'd1, 16'd100, 16'd5, 1'b0);
        handshake();
        wait_cent(c);
        check("p1_empty_latency", 64'(c), 64'd2);
        expect_cent("p1_c2", 2'd2, 16'd0, 16'd0, 1'b1);
        handshake();
        check("p1_ready_back", 64'(pt_ready), 64'd1);

        // ---------------- pass 2: back-pressure at idx 1
        send(16'd10, 16'd20, 2'd0, 1'b0);
        send(16'd12, 16'd22, 2'd0, 1'b0);
        send(16'd14, 16'd27, 2'd0, 1'b0);
        send(16'd100, 16'd5, 2'd1, 1'b1);
        expect_cent("p2_c0", 2'd0, 16'd12, 16'd23, 1'b0);
        handshake();
        expect_cent("p2_c1", 2'd1, 16'd100, 16'd5, 1'b0);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cent_valid !== 1'b1 || cent_idx !== 2'd1 || cent_x !== 16'd100 ||
                cent_y !== 16'd5 || cent_empty !== 1'b0)
                stable = 1'b0;
        end
        check("p2_stall_stable", 64'(stable), 64'd1);
        check("p2_ready_in_out", 64'(pt_ready), 64'd0);
        handshake();
        wait_cent(c);
        check("p2_idx2_latency", 64'(c), 64'd2);
        expect_cent("p2_c2", 2'd2, 16'd0, 16'd0, 1'b1);
        handshake();
        check("p2_ready_back", 64'(pt_ready), 64'd1);

        // ---------------- pass 3: illegal address is dropped and flagged
        send(16'd4, 16'd6, 2'd0, 1'b0);
        send(16'd500, 16'd500, 2'd3, 1'b0);
        send(16'd9, 16'd3, 2'd1, 1'b1);
        expect_cent("p3_c0", 2'd0, 16'd4, 16'd6, 1'b0);
        check("p3_err_addr", 64'(err_addr), 64'd1);
        check("p3_err_ovf", 64'(err_ovf), 64'd0);
        handshake();
        expect_cent("p3_c1", 2'd1, 16'd9, 16'd3, 1'b0);
        handshake();
        expect_cent("p3_c2", 2'd2, 16'd0, 16'd0, 1'b1);
        check("p3_err_addr_held", 64'(err_addr), 64'd1);
        handshake();
        check("p3_err_addr_clr", 64'(err_addr), 64'd0);

        // ---------------- pass 4: floor rounding, points ignored outside ACCUM
        send(16'd1, 16'd1, 2'd2, 1'b0);
        send(16'd2, 16'd4, 2'd2, 1'b1);
        pt_valid     = 1'b1;
        pt_x         = 16'd999;
        pt_y         = 16'd999;
        cluster_addr = 2'd0;
        pt_last      = 1'b1;
        expect_cent("p4_c0", 2'd0, 16'd0, 16'd0, 1'b1);
        check("p4_ready_low", 64'(pt_ready), 64'd0);
        pt_valid = 1'b0;
        pt_last  = 1'b0;
        handshake();
        expect_cent("p4_c1", 2'd1, 16'd0, 16'd0, 1'b1);
        handshake();
        expect_cent("p4_c2", 2'd2, 16'd1, 16'd2, 1'b0);
        handshake();

        // ---------------- pass 5: reset during DIV_Y of cluster 1
        send(16'd10, 16'd20, 2'd0, 1'b0);
        send(16'd500, 16'd500, 2'd3, 1'b0);
        send(16'd100, 16'd5, 2'd1, 1'b1);
        expect_cent("p5_c0", 2'd0, 16'd10, 16'd20, 1'b0);
        handshake();
        for (int i = 0; i < 40; i++) tick();
        check("p5_err_before_rst", 64'(err_addr), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("p5_reset_outs", 64'(all_outs()), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        send(16'd7, 16'd9, 2'd0, 1'b1);
        expect_cent("p5_new_c0", 2'd0, 16'd7, 16'd9, 1'b0);
        handshake();
        expect_cent("p5_new_c1", 2'd1, 16'd0, 16'd0, 1'b1);
        handshake();
        expect_cent("p5_new_c2", 2'd2, 16'd0, 16'd0, 1'b1);
        handshake();

        // ---------------- pass 6: counter saturation
        // 65535 points to cluster 0: x = 10, y alternates 4,2 starting with 4.
        // sum_y = 32768*4 + 32767*2 = 196606, mean = 3.
        c = 0;
        while (!pt_ready && c < 200) begin
            tick();
            c++;
        end
        pt_valid     = 1'b1;
        pt_last      = 1'b0;
        cluster_addr = 2'd0;
        pt_x         = 16'd10;
        for (int i = 0; i < 65535; i++) begin
            pt_y = (i % 2 == 0) ? 16'd4 : 16'd2;
            tick();
        end
        pt_valid = 1'b0;
        check("p6_no_ovf_yet", 64'(err_ovf), 64'd0);
        send(16'd60000, 16'd60000, 2'd0, 1'b1);
        expect_cent("p6_c0", 2'd0, 16'd10, 16'd3, 1'b0);
        check("p6_err_ovf", 64'(err_ovf), 64'd1);
        check("p6_err_addr", 64'(err_addr), 64'd0);
        handshake();
        expect_cent("p6_c1", 2'd1, 16'd0, 16'd0, 1'b1);
        handshake();
        expect_cent("p6_c2", 2'd2, 16'd0, 16'd0, 1'b1);
        handshake();
        check("p6_err_ovf_clr", 64'(err_ovf), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/centroid_update_unit.md
Name: centroid_update_unit

Overview:
- Consumer of the 2-bit cluster address produced by the least-distance (LTA) stage of the K-means processor, K = 3 clusters.
- Accumulates per-cluster coordinate sums and point counts for 2-D points during one clustering pass.
- After the last point, computes each new centroid (sum / count) with a sequential restoring divider.
- Streams the three centroids back to the distance stage over a valid/ready interface.

Parameters:
- COORD_W, 16, width of unsigned point coordinates x and y.
- CNT_W, 16, width of each per-cluster point counter.
- SUM_W, COORD_W+CNT_W, width of each per-cluster sum accumulator and of the divider datapath.

Ports:
- clk, in, 1, single clock; all state changes on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- pt_valid, in, 1, point/address pair valid.
- pt_ready, out, 1, unit accepts a point; high only in ACCUM.
- pt_x, in, COORD_W, point x coordinate.
- pt_y, in, COORD_W, point y coordinate.
- cluster_addr, in, 2, winning cluster (00/01/10); 11 is illegal.
- pt_last, in, 1, qualifies the final point of the pass.
- cent_valid, out, 1, centroid output valid.
- cent_ready, in, 1, downstream accepts the centroid.
- cent_idx, out, 2, index of the presented centroid.
- cent_x, out, COORD_W, new centroid x.
- cent_y, out, COORD_W, new centroid y.
- cent_empty, out, 1, cluster received zero points; cent_x and cent_y are 0.
- err_addr, out, 1, sticky: an illegal address was received this pass.
- err_ovf, out, 1, sticky: a point was dropped because its cluster counter was saturated.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to ACCUM.
  - All sums, counts, divider registers and outputs clear to 0, including pt_ready, cent_valid, cent_idx, cent_x, cent_y, cent_empty, err_addr and err_ovf.
  - pt_ready rises in the first cycle after rst_n deasserts.
  - Reset mid-pass discards all accumulated data.
- States: ACCUM, DIV_X, DIV_Y, OUT.
- ACCUM:
  - pt_ready = 1. A point is accepted when pt_valid & pt_ready.
  - Accepted point with addr k ≤ 2 and count[k] ≠ all-ones: sum_x[k] += pt_x, sum_y[k] += pt_y, count[k] += 1. Values are zero-extended; sums cannot overflow in SUM_W.
  - Accepted point with addr = 11: point dropped, err_addr set.
  - Accepted point whose count[k] is all-ones: point dropped, err_ovf set.
  - Accepted point with pt_last = 1 is processed under the same rules, then the unit sets k = 0 and goes to DIV_X. pt_ready falls on the next cycle.
  - pt_last without pt_valid is ignored.
- DIV_X:
  - If count[k] = 0: skip division, set cent_x = cent_y = 0 and cent_empty = 1, go to OUT after 1 cycle.
  - Otherwise: restoring division of sum_x[k] by count[k], one quotient bit per cycle, MSB first, exactly SUM_W cycles.
  - Quotient is truncated to COORD_W bits; it always fits because mean ≤ max coordinate.
  - Then go to DIV_Y.
- DIV_Y: same division on sum_y[k], SUM_W cycles, then go to OUT.
- OUT:
  - cent_valid = 1, cent_idx = k.
  - cent_x, cent_y and cent_empty are held stable until cent_ready.
  - On the handshake with k < 2: k += 1, go to DIV_X; cent_valid falls the next cycle.
  - On the handshake with k = 2: clear all sums, counts, err_addr and err_ovf; go to ACCUM.
- Latency: with a nonzero count, cent_valid rises 2·SUM_W+1 rising edges after the edge that accepts pt_last (65 edges at defaults). With a zero count, it rises 2 edges after the preceding handshake or the pt_last acceptance.
- cent_ready while cent_valid is low has no effect.
- err flags are readable during OUT and clear only at the final handshake or on reset.

Test Plan:
- Cluster 0 receives (10,20), (12,22), (14,27); cluster 1 receives (100,5) as the last point → cluster 0: idx 0, (12,23), empty 0. Cluster 1: idx 1, (100,5). Cluster 2: idx 2, (0,0), empty 1. cent_valid for cluster 0 rises 65 edges after the pt_last accept edge.
- Same stimulus with cent_ready held low for 10 cycles at idx 1 → outputs stay stable, no advance; after cent_ready the idx 2 centroid arrives 2 edges later; pt_ready returns after the idx 2 handshake.
- Include one point with addr = 11 (500,500) → that point is excluded from all centroids; err_addr = 1 during OUT; err_addr = 0 after the pass ends.
- Rounding check: cluster 2 receives (1,1) and (2,4) → (1,2) (floor division); pt_valid held high in DIV/OUT is not accepted (pt_ready = 0).
- Assert rst_n low while in DIV_Y of cluster 1 → all outputs 0 immediately; a new pass with a single point (7,9) to cluster 0 gives cluster 0 (7,9) and empty = 1 for clusters 1 and 2.
- Force count[0] = 0xFFFF (65535 points to cluster 0), then one more point to cluster 0 → that point is dropped, err_ovf = 1, centroid equals the mean of the first 65535 points.
